nonlinear_stage: RTL

Registered nonlinear layer of the SWAN64 parallel round datapath: XORs a 32-bit round-key half into one 32-bit Feistel side, applies a bitsliced 4-bit S-box across the four 8-bit columns, and presents the result to the linear (column-mixing) layer directly downstream. Two-stage elastic pipeline with valid/ready handshakes on both sides, so round-control logic can stall or stream blocks freely.

---
 rtl/nonlinear_stage_if.sv | 34 +++
 rtl/nonlinear_stage.sv | 93 +++++++++
 2 files changed

// File: rtl/nonlinear_stage_if.sv
// nonlinear_stage_if
//   Handshake bundle for the SWAN64 nonlinear stage: the upstream valid/ready
//   channel carrying one Feistel side plus a round-key half, and the
//   downstream valid/ready channel carrying the S-box layer result.
//   Words use [0:SIDE_SIZE-1] packing, so bit 0 is the MSB.
//
//   in_valid / in_ready   upstream handshake
//   in_x, in_k            side data and round-key half
//   out_valid / out_ready downstream handshake
//   out_y                 S-box layer result
//
//   master: the environment, which drives inputs and out_ready.
//   slave : the stage itself.
interface nonlinear_stage_if #(
  parameter int SIDE_SIZE = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [0:SIDE_SIZE-1] in_x;
  logic [0:SIDE_SIZE-1] in_k;
  logic                 out_valid;
  logic                 out_ready;
  logic [0:SIDE_SIZE-1] out_y;

  modport master (
    output in_valid, in_x, in_k, out_ready,
    input  in_ready, out_valid, out_y
  );

  modport slave (
    input  in_valid, in_x, in_k, out_ready,
    output in_ready, out_valid, out_y
  );
endinterface

// File: rtl/nonlinear_stage.sv
// nonlinear_stage
//   Registered nonlinear layer of the SWAN64 round datapath. Stage 1 captures
//   in_x ^ in_k; stage 2 captures the bitsliced 4-bit S-box layer of that sum.
//   Two-entry elastic pipeline with valid/ready on both sides.
//
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    nonlinear_stage_if.slave (in_valid/in_ready/in_x/in_k,
//          out_valid/out_ready/out_y)
module nonlinear_stage #(
  parameter int BLOCK_SIZE = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  nonlinear_stage_if.slave   bus
);
  localparam int SIDE_SIZE   = BLOCK_SIZE / 2;
  localparam int COLUMN_SIZE = SIDE_SIZE / 4;

  logic                 s1_v;
  logic                 s2_v;
  logic [0:SIDE_SIZE-1] s1_d;
  logic [0:SIDE_SIZE-1] s2_d;
  logic                 s1_en;
  logic                 s2_en;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] s;
    case (n)
      4'h0: s = 4'hC;
      4'h1: s = 4'h5;
      4'h2: s = 4'h6;
      4'h3: s = 4'hB;
      4'h4: s = 4'h9;
      4'h5: s = 4'h0;
      4'h6: s = 4'hA;
      4'h7: s = 4'hD;
      4'h8: s = 4'h3;
      4'h9: s = 4'hE;
      4'hA: s = 4'hF;
      4'hB: s = 4'h8;
      4'hC: s = 4'h4;
      4'hD: s = 4'h7;
      4'hE: s = 4'h1;
      default: s = 4'h2;
    endcase
    return s;
  endfunction

  // Bit j of each of the four columns forms one nibble, column 0 as MSB;
  // the S-box output is scattered back to the same four positions.
  function automatic logic [0:SIDE_SIZE-1] sbl(input logic [0:SIDE_SIZE-1] a);
    logic [0:SIDE_SIZE-1] r;
    logic [3:0]           n;
    logic [3:0]           s;
    r = '0;
    for (int j = 0; j < COLUMN_SIZE; j++) begin
      n = {a[j], a[COLUMN_SIZE + j], a[2*COLUMN_SIZE + j], a[3*COLUMN_SIZE + j]};
      s = sbox(n);
      r[j]                 = s[3];
      r[COLUMN_SIZE + j]   = s[2];
      r[2*COLUMN_SIZE + j] = s[1];
      r[3*COLUMN_SIZE + j] = s[0];
    end
    return r;
  endfunction

  // Ready ripples back combinationally so a full pipe still streams 1/cycle.
  assign s2_en        = !s2_v || bus.out_ready;
  assign s1_en        = !s1_v || s2_en;
  assign bus.in_ready = s1_en;

  assign bus.out_valid = s2_v;
  assign bus.out_y     = s2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_d <= '0;
      s2_v <= 1'b0;
      s2_d <= '0;
    end else begin
      if (s1_en) begin
        s1_v <= bus.in_valid;
        if (bus.in_valid) s1_d <= bus.in_x ^ bus.in_k;
      end
      if (s2_en) begin
        s2_v <= s1_v;
        if (s1_v) s2_d <= sbl(s1_d);
      end
    end
  end
endmodule
